// File: rtl/mem_dump_pkg.sv
// Shared types for the memory dump reader: FSM state encoding and the streamed data width.
package mem_dump_pkg;

    localparam int DUMP_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        SEND,
        CSUM,
        FIN
    } dump_state_t;

endpackage

// File: rtl/mem_dump_unit_if.sv
// Bundle for the dump reader: core completion flag, data-memory read port and the byte stream.
// master = the dump unit, slave = its environment (core, data memory, consumer).
interface mem_dump_unit_if
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = 8
);

    logic                   done_in;
    logic                   mem_rd_en;
    logic [ADDR_W-1:0]      mem_rd_addr;
    logic [DUMP_DATA_W-1:0] mem_rd_data;
    logic [DUMP_DATA_W-1:0] dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   dump_done;

    modport master (
        input  done_in,
        input  mem_rd_data,
        input  dout_ready,
        output mem_rd_en,
        output mem_rd_addr,
        output dout,
        output dout_valid,
        output dump_done
    );

    modport slave (
        output done_in,
        output mem_rd_data,
        output dout_ready,
        input  mem_rd_en,
        input  mem_rd_addr,
        input  dout,
        input  dout_valid,
        input  dump_done
    );

endinterface

// File: rtl/mem_dump_unit.sv
// Memory dump reader: once done_in is seen, streams bytes START_ADDR..START_ADDR+LEN-1 (wrapping) out.
// Define DUMP_CHECKSUM_EN to append one XOR-of-all-bytes checksum byte after the window.
module mem_dump_unit
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0,
    parameter int LEN        = 16
) (
    input  logic            clk,
    input  logic            reset,
    mem_dump_unit_if.master bus
);

    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(LEN - 1);
`ifdef DUMP_CHECKSUM_EN
    localparam dump_state_t AFTER_DATA = CSUM;
`else
    localparam dump_state_t AFTER_DATA = FIN;
`endif

    generate
        if (LEN < 1 || LEN > (1 << ADDR_W)) begin : g_len_check
            $error("mem_dump_unit: LEN must lie in 1..2**ADDR_W");
        end
    endgenerate

    dump_state_t            r_state;
    dump_state_t            w_next_state;
    logic [ADDR_W:0]        r_index;
    logic [DUMP_DATA_W-1:0] r_dout;
    logic                   r_dout_valid;
    logic                   r_dump_done;
    logic                   w_rd_en;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic                   w_xfer;
    logic                   w_last;

    assign w_xfer = r_dout_valid & bus.dout_ready;
    assign w_last = (r_index == LAST_IDX);

    // NOTE: clocked state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (bus.done_in) w_next_state = REQ;
            REQ:     w_next_state = CAP;
            CAP:     w_next_state = SEND;
            SEND:    if (w_xfer) w_next_state = w_last ? AFTER_DATA : REQ;
`ifdef DUMP_CHECKSUM_EN
            CSUM:    if (w_xfer) w_next_state = FIN;
`endif
            FIN:     w_next_state = FIN;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_rd_en   = (r_state == REQ);
        w_rd_addr = START_A + r_index[ADDR_W-1:0];
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DUMP_DATA_W-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset)               r_csum <= '0;
        else if (r_state == CAP) r_csum <= r_csum ^ bus.mem_rd_data;
    end
`endif

    // Byte register: loaded from the read port in CAP, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_index      <= '0;
            r_dump_done  <= 1'b0;
        end else begin
            case (r_state)
                CAP: begin
                    r_dout       <= bus.mem_rd_data;
                    r_dout_valid <= 1'b1;
                end
                SEND: begin
                    if (w_xfer) begin
                        r_index <= r_index + 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        if (w_last) r_dout <= r_csum;
                        r_dout_valid <= w_last;
`else
                        r_dout_valid <= 1'b0;
`endif
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: if (w_xfer) r_dout_valid <= 1'b0;
`endif
                default: ;
            endcase
            if (w_next_state == FIN) r_dump_done <= 1'b1;
        end
    end

    assign bus.mem_rd_en   = w_rd_en;
    assign bus.mem_rd_addr = w_rd_addr;
    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.dump_done   = r_dump_done;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Self-checking bench for mem_dump_unit: wrapping window 254..1, table vectors, random backpressure runs.
// Expects the checksum byte only when DUMP_CHECKSUM_EN is defined for the build.
module tb_mem_dump_unit;

    localparam int ADDR_W = 8;
    localparam int START  = 254;
    localparam int LEN    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_dump_unit_if #(.ADDR_W(ADDR_W)) bus();

    mem_dump_unit #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START),
        .LEN       (LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Data memory: synchronous read, data one cycle after the strobe.
    logic [7:0] mem [256];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] got_b[$];

    typedef struct {
        logic [31:0] m;
        int          stall_pct;
        logic [31:0] exp_bytes;
        logic [7:0]  exp_csum;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.done_in = 1'b0;
        bus.dout_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full dump under random ready; compared against the window model built from mem[].
    task automatic run_dump(input int stall_pct, input string tag);
        logic [7:0] exp_a[$];
        logic [7:0] exp_b[$];
        logic [7:0] got_a[$];
        logic [7:0] x;
        logic [7:0] a;
        logic [7:0] held;
        logic       stalled;
        int         cyc;
        int         last_x;
        x = 8'h00;
        for (int i = 0; i < LEN; i++) begin
            a = 8'((START + i) % 256);
            exp_a.push_back(a);
            exp_b.push_back(mem[a]);
            x = x ^ mem[a];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_b.push_back(x);
`endif
        got_b.delete();
        stalled = 1'b0;
        held = 8'h00;
        cyc = 0;
        last_x = -1;
        @(negedge clk);
        bus.done_in = 1'b1;
        bus.dout_ready = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.mem_rd_en) got_a.push_back(bus.mem_rd_addr);
            if (stalled) begin
                check({tag, " held dout"}, bus.dout, held);
                check({tag, " held valid"}, bus.dout_valid, 1);
                check({tag, " no read while held"}, bus.mem_rd_en, 0);
            end
            bus.done_in = 1'($urandom_range(0, 1));
            bus.dout_ready = ($urandom_range(0, 99) >= stall_pct);
            stalled = bus.dout_valid && !bus.dout_ready;
            held = bus.dout;
            if (bus.dout_valid && bus.dout_ready) begin
                got_b.push_back(bus.dout);
                last_x = cyc;
            end
        end while (!bus.dump_done && cyc < 2000);
        bus.dout_ready = 1'b0;
        check({tag, " dump finished in budget"}, bus.dump_done, 1);
        check({tag, " dump_done one cycle after last transfer"}, cyc, last_x + 1);
        check({tag, " byte count"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            check($sformatf("%s byte %0d", tag, i), (i < got_b.size()) ? 32'(got_b[i]) : 32'hDEAD, exp_b[i]);
        check({tag, " read count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++)
            check($sformatf("%s addr %0d", tag, i), (i < got_a.size()) ? 32'(got_a[i]) : 32'hDEAD, exp_a[i]);
    endtask

    task automatic seq_latency_backpressure();
        do_reset();
        mem[254] = 8'hA5;
        mem[255] = 8'h5B;
        bus.dout_ready = 1'b0;
        bus.done_in = 1'b1;
        @(negedge clk);
        bus.done_in = 1'b0;
        check("lat rd_en at t+1", bus.mem_rd_en, 1);
        check("lat first addr", bus.mem_rd_addr, 254);
        @(negedge clk);
        check("lat rd_en single cycle", bus.mem_rd_en, 0);
        check("lat valid not yet", bus.dout_valid, 0);
        @(negedge clk);
        check("lat valid after t+2", bus.dout_valid, 1);
        check("lat first byte", bus.dout, 8'hA5);
        repeat (5) begin
            @(negedge clk);
            check("bp dout held", bus.dout, 8'hA5);
            check("bp valid held", bus.dout_valid, 1);
            check("bp no read", bus.mem_rd_en, 0);
        end
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.dout_ready = 1'b0;
        check("bp next read after release", bus.mem_rd_en, 1);
        check("bp next addr wraps", bus.mem_rd_addr, 255);
        check("bp valid dropped", bus.dout_valid, 0);
    endtask

    task automatic seq_reset_mid_dump();
        int  nb;
        int  cyc;
        logic reached;
        do_reset();
        nb = 0;
        cyc = 0;
        reached = 1'b0;
        bus.dout_ready = 1'b1;
        bus.done_in = 1'b1;
        while (cyc < 100 && !reached) begin
            @(negedge clk);
            cyc++;
            bus.done_in = 1'b0;
            if (bus.dout_valid) begin
                if (nb == 2) reached = 1'b1;
                else nb++;
            end
        end
        check("rst reached byte 3", reached, 1);
        bus.dout_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst valid cleared", bus.dout_valid, 0);
        check("rst dump_done clear", bus.dump_done, 0);
        check("rst no read", bus.mem_rd_en, 0);
        check("rst addr back to start", bus.mem_rd_addr, START);
        @(negedge clk);
        check("rst stays idle", bus.mem_rd_en, 0);
        run_dump(30, "restart");
    endtask

    initial begin
        vecs[0] = '{m: 32'h11223344, stall_pct: 0,  exp_bytes: 32'h11223344, exp_csum: 8'h44};
        vecs[1] = '{m: 32'h0001FF80, stall_pct: 50, exp_bytes: 32'h0001FF80, exp_csum: 8'h7E};
        vecs[2] = '{m: 32'hA55AC33C, stall_pct: 80, exp_bytes: 32'hA55AC33C, exp_csum: 8'h00};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        reset = 1'b1;
        bus.done_in = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rd_en", bus.mem_rd_en, 0);
        check("reset addr", bus.mem_rd_addr, START);
        check("reset dout", bus.dout, 0);
        check("reset valid", bus.dout_valid, 0);
        check("reset dump_done", bus.dump_done, 0);
        reset = 1'b0;

        seq_latency_backpressure();
        seq_reset_mid_dump();

        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int i = 0; i < LEN; i++) mem[8'((START + i) % 256)] = vecs[v].m[31 - 8*i -: 8];
            run_dump(vecs[v].stall_pct, $sformatf("vec%0d", v));
            for (int i = 0; i < LEN; i++)
                check($sformatf("vec%0d table byte %0d", v, i),
                      (i < got_b.size()) ? 32'(got_b[i]) : 32'hDEAD, vecs[v].exp_bytes[31 - 8*i -: 8]);
`ifdef DUMP_CHECKSUM_EN
            check($sformatf("vec%0d table checksum", v),
                  (LEN < got_b.size()) ? 32'(got_b[LEN]) : 32'hDEAD, vecs[v].exp_csum);
`endif
        end

        for (int r = 0; r < 20; r++) begin
            do_reset();
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            run_dump(int'($urandom_range(0, 70)), $sformatf("rand%0d", r));
        end

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.done_in = ~bus.done_in;
            bus.dout_ready = 1'($urandom_range(0, 1));
            check("fin no read", bus.mem_rd_en, 0);
            check("fin done sticky", bus.dump_done, 1);
            check("fin no valid", bus.dout_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
